// File: rtl/pipelined_carry_adder.sv
// WIDTH-bit adder with the carry chain split into STAGES registered ripple segments and a
// valid/ready handshake on both sides. Define PIPE_ADDER_SUB_EN to add the sub port (a - b).
module pipelined_carry_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
`ifdef PIPE_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             ovf
);

    localparam int SEG  = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    generate
        if (WIDTH < 2 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_param
            $error("pipelined_carry_adder: need WIDTH>=2, 1<=STAGES<=WIDTH, WIDTH%%STAGES==0");
        end
    endgenerate

    logic             adv;
    logic [STAGES-1:0] v_q;
    logic [STAGES:0]   pv;
    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] s_q [STAGES];
    logic [STAGES-1:0] c_q;

    logic [WIDTH-1:0] b_eff;
    logic             c_first;

    // pa/pb/ps/pc[k] are the inputs of segment k: entry 0 is the port side, entry k+1 is stage k
    logic [WIDTH-1:0] pa [STAGES+1];
    logic [WIDTH-1:0] pb [STAGES+1];
    logic [WIDTH-1:0] ps [STAGES+1];
    logic [STAGES:0]  pc;

    logic [WIDTH-1:0] nx_s [STAGES];
    logic [STAGES-1:0] nx_c;
    logic             cy;

    assign adv       = ~out_valid | out_ready;
    assign in_ready  = adv & ~rst;
    assign out_valid = v_q[LAST];
    assign pv        = {v_q, in_valid};

`ifdef PIPE_ADDER_SUB_EN
    assign b_eff   = sub ? ~b : b;
    assign c_first = sub ? 1'b1 : c_in;
`else
    assign b_eff   = b;
    assign c_first = c_in;
`endif

    always_comb begin
        pa[0] = a;
        pb[0] = b_eff;
        ps[0] = '0;
        pc[0] = c_first;
        for (int k = 0; k < STAGES; k++) begin
            pa[k+1] = a_q[k];
            pb[k+1] = b_q[k];
            ps[k+1] = s_q[k];
            pc[k+1] = c_q[k];
        end
    end

    // Each segment ripples through its SEG bits and leaves already-finished slices untouched
    always_comb begin
        cy = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            nx_s[k] = ps[k];
            cy      = pc[k];
            for (int i = 0; i < SEG; i++) begin
                nx_s[k][k*SEG+i] = pa[k][k*SEG+i] ^ pb[k][k*SEG+i] ^ cy;
                cy = (pa[k][k*SEG+i] & pb[k][k*SEG+i]) | (cy & (pa[k][k*SEG+i] ^ pb[k][k*SEG+i]));
            end
            nx_c[k] = cy;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q       <= '0;
            a_q[LAST] <= '0;
            b_q[LAST] <= '0;
            s_q[LAST] <= '0;
            c_q[LAST] <= 1'b0;
        end else if (adv) begin
            v_q <= pv[STAGES-1:0];
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= pa[k];
                b_q[k] <= pb[k];
                s_q[k] <= nx_s[k];
                c_q[k] <= nx_c[k];
            end
        end
    end

    assign s     = s_q[LAST];
    assign c_out = c_q[LAST];
    assign ovf   = (a_q[LAST][WIDTH-1] == b_q[LAST][WIDTH-1]) &
                   (s_q[LAST][WIDTH-1] != a_q[LAST][WIDTH-1]);

endmodule
